// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - 256-bit cache line to 64-bit 4-beat memory burst adaptor
//
// Sits between the L1 cache and main memory. It assembles four read beats
// into one line, or splits one write line into four beats. It then gives the
// cache a single-cycle completion pulse.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   line_i / line_o      cache write line / assembled read line
//   address_i            cache line address (offset bits ignored)
//   read_i, write_i      cache line requests (read wins if both)
//   resp_o               one-cycle line completion pulse
//   burst_i / burst_o    memory read beat / write beat
//   address_o            32-byte aligned burst address, stable per transfer
//   read_o, write_o      memory burst requests
//   resp_i               memory beat valid (read) / accepted (write)
module cacheline_adaptor #(
  parameter int s_line   = 256,
  parameter int s_burst  = 64,
  parameter int s_offset = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int beats = s_line / s_burst;
  localparam int cw    = $clog2(beats);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state;
  state_t            state_n;
  logic [cw-1:0]     count;
  logic [s_line-1:0] wbuf;
  logic              last_beat;

  // The final beat is the one accepted while the counter sits at its top value.
  // The counter then wraps to zero on the same edge that leaves the state.
  assign last_beat = resp_i && (count == cw'(beats - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (read_i) begin
          state_n = READ;
        end else if (write_i) begin
          state_n = WRITE;
        end
      end
      READ: begin
        if (last_beat) begin
          state_n = DONE;
        end
      end
      WRITE: begin
        if (last_beat) begin
          state_n = DONE;
        end
      end
      DONE: begin
        // Requests are not sampled here: the cache drops them on resp_o.
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    read_o  = 1'b0;
    write_o = 1'b0;
    resp_o  = 1'b0;
    burst_o = '0;
    case (state)
      READ:  read_o = 1'b1;
      WRITE: begin
        write_o = 1'b1;
        burst_o = wbuf[s_burst*count +: s_burst];
      end
      DONE:  resp_o = 1'b1;
      default: ;
    endcase
  end

  // Datapath: burst address, beat counter, write buffer, read line
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      address_o <= '0;
      wbuf      <= '0;
      line_o    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (read_i || write_i) begin
            count     <= '0;
            address_o <= {address_i[31:s_offset], {s_offset{1'b0}}};
          end
          if (!read_i && write_i) begin
            wbuf <= line_i;
          end
        end
        READ: begin
          if (resp_i) begin
            line_o[s_burst*count +: s_burst] <= burst_i;
            count <= count + 1'b1;
          end
        end
        WRITE: begin
          if (resp_i) begin
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
